fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Fetch stage that sits directly upstream of the instruction decoder. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents one fetched instruction and its PC to decode over a valid/ready handshake. It accepts resolved control-flow redirects (j, jal, jr, bne, blt, bex) from execute, computes the next PC, and squashes wrong-path fetches.

Parameters:
PC_W, 12, PC / imem word-address width
INSN_W, 32, instruction width
RESET_PC, 0, PC loaded on reset

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-low (0 = reset)
imem_req  out  1  read request, held until imem_ack
imem_addr  out  PC_W  word address; stable while imem_req=1
imem_ack  in  1  one-cycle pulse, imem_rdata valid; earliest one cycle after imem_req rises
imem_rdata  in  INSN_W  fetched word
out_valid  out  1  instruction available to decode
out_insn  out  INSN_W  instruction to decode (opcode = out_insn[31:27])
out_pc  out  PC_W  address of out_insn
out_ready  in  1  decode accepts when out_valid & out_ready
redir_valid  in  1  execute presents a control-flow insn this cycle
redir_j, redir_jal, redir_jr, redir_bne, redir_blt, redir_bex  in  1 each  type flags
cond_ne, cond_lt, cond_rstatus_nz  in  1 each  resolved conditions
redir_pc  in  PC_W  PC of the control-flow insn
redir_imm  in  17  branch offset, two's complement
redir_target  in  27  jump target field
redir_rd_val  in  32  register value for jr
redir_taken  out  1  combinational: redirect taken this cycle (flush signal for later stages)
fetch_count  out  16  instructions delivered to decode

Behaviour:
- taken = redir_valid & (jr | j | jal | (bex & cond_rstatus_nz) | (blt & cond_lt) | (bne & cond_ne)).
- Target priority if several flags set: jr > j/jal > bex > blt > bne. jr -> redir_rd_val[PC_W-1:0]; j/jal/bex -> redir_target[PC_W-1:0]; blt/bne -> redir_pc + 1 + sign_ext(redir_imm), modulo 2^PC_W.
- Sequential PC increment pc+1 wraps 2^PC_W-1 -> 0.
- Reset (reset=0, sampled at edge) overrides everything: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, out_valid=0, out_insn=0, out_pc=0, fetch_count=0. Acks arriving in or after reset are ignored.
- States:
  IDLE: imem_req=0; ack ignored; -> FETCH next cycle.
  FETCH: imem_req=1, imem_addr=pc (registered copy).
    ack & ~taken: out_insn<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+1 -> HOLD.
    ack & taken: discard rdata, pc<=target, stay FETCH (new address next cycle).
    ~ack & taken: pc<=target -> DROP.
  DROP: imem_req=1, imem_addr unchanged (old request outstanding). Further taken redirects update pc (latest wins). On ack: discard rdata -> FETCH.
  HOLD: imem_req=0; out_valid=1, out_insn/out_pc stable until accepted.
    taken: out_valid<=0 (squash, not counted), pc<=target -> FETCH; taken wins over out_ready.
    out_ready & ~taken: out_valid<=0, fetch_count+1 (wraps 0xFFFF -> 0) -> FETCH.
- Throughput: one instruction per (imem latency + 2) cycles; no prefetch.
- redirect inputs ignored when redir_valid=0; non-taken branches have no effect.

Test Plan:
- Reset low 2 cycles then high; ack 2 cycles after req, rdata=0x28000005 -> imem_addr=0, out_valid=1, out_insn=0x28000005, out_pc=0; after out_ready next imem_addr=1, fetch_count=1.
- In HOLD, redir_valid=1, redir_blt=1, cond_lt=1, redir_pc=10, redir_imm=0x1FFFC -> redir_taken=1, out_valid drops without count, next imem_addr=7.
- In FETCH (addr=3, no ack), jr with redir_rd_val=0x00000040 -> DROP, imem_addr stays 3 until ack, rdata discarded (out_valid stays 0), then imem_addr=0x040.
- out_ready held low 5 cycles in HOLD -> out_valid, out_insn, out_pc constant, imem_req=0, fetch_count unchanged.
- pc=0xFFF, ack with rdata=0x08000002 -> out_pc=0xFFF, next imem_addr=0x000.
- reset driven low while FETCH awaiting ack, ack arrives during reset -> all outputs at reset values, ack ignored, first post-reset imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack and hands one
// instruction at a time to decode, applying resolved control-flow redirects.
module fetch_pc_unit #(
  parameter int              PC_W     = 12,
  parameter int              INSN_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [INSN_W-1:0] out_insn,
  output logic [PC_W-1:0]   out_pc,
  input  logic              out_ready,
  input  logic              redir_valid,
  input  logic              redir_j,
  input  logic              redir_jal,
  input  logic              redir_jr,
  input  logic              redir_bne,
  input  logic              redir_blt,
  input  logic              redir_bex,
  input  logic              cond_ne,
  input  logic              cond_lt,
  input  logic              cond_rstatus_nz,
  input  logic [PC_W-1:0]   redir_pc,
  input  logic [16:0]       redir_imm,
  input  logic [26:0]       redir_target,
  input  logic [31:0]       redir_rd_val,
  output logic              redir_taken,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     w_pc_nxt;
  logic [PC_W-1:0]     w_target;
  logic [PC_W-1:0]     w_br_target;
  logic [PC_W-1:0]     r_addr;
  logic                r_req;
  logic                r_valid;
  logic [INSN_W-1:0]   r_insn;
  logic [PC_W-1:0]     r_out_pc;
  logic [15:0]         r_count;
  logic                w_taken;
  logic                w_load_out;
  logic                w_accept;
  logic                w_squash;

  function automatic logic [PC_W-1:0] sext_imm(input logic [16:0] imm);
    logic [PC_W-1:0] res;
    for (int i = 0; i < PC_W; i++) begin
      res[i] = imm[(i < 17) ? i : 16];
    end
    return res;
  endfunction

  assign w_taken = redir_valid & (redir_jr | redir_j | redir_jal |
                                  (redir_bex & cond_rstatus_nz) |
                                  (redir_blt & cond_lt) |
                                  (redir_bne & cond_ne));

  // Redirect target, jr first, then absolute jumps/bex, then relative branches.
  always_comb begin
    w_br_target = redir_pc + {{(PC_W-1){1'b0}}, 1'b1} + sext_imm(redir_imm);
    if (redir_jr) begin
      w_target = redir_rd_val[PC_W-1:0];
    end else if (redir_j | redir_jal | redir_bex) begin
      w_target = redir_target[PC_W-1:0];
    end else begin
      w_target = w_br_target;
    end
  end

  // Next state and next PC.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load_out  = 1'b0;
    w_accept    = 1'b0;
    w_squash    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack && !w_taken) begin
          w_load_out  = 1'b1;
          w_pc_nxt    = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
          w_state_nxt = S_HOLD;
        end else if (imem_ack) begin
          w_pc_nxt    = w_target;
        end else if (w_taken) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_DROP;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DROP: begin
        // The stale request is still outstanding; its data is thrown away.
        if (w_taken) begin
          w_pc_nxt = w_target;
        end else begin
          w_pc_nxt = r_pc;
        end
        if (imem_ack) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      S_HOLD: begin
        if (w_taken) begin
          w_squash    = 1'b1;
          w_pc_nxt    = w_target;
          w_state_nxt = S_FETCH;
        end else if (out_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, PC, memory request and decode-side output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req    <= 1'b0;
      r_addr   <= {PC_W{1'b0}};
      r_valid  <= 1'b0;
      r_insn   <= {INSN_W{1'b0}};
      r_out_pc <= {PC_W{1'b0}};
      r_count  <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_req   <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_DROP);
      if (w_state_nxt == S_FETCH) begin
        r_addr <= w_pc_nxt;
      end
      if (w_load_out) begin
        r_valid  <= 1'b1;
        r_insn   <= imem_rdata;
        r_out_pc <= r_pc;
      end else if (w_accept || w_squash) begin
        r_valid <= 1'b0;
      end
      if (w_accept) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign out_valid   = r_valid;
  assign out_insn    = r_insn;
  assign out_pc      = r_out_pc;
  assign fetch_count = r_count;
  assign redir_taken = w_taken;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with hand-computed expected values.
module tb_fetch_pc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_insn;
  logic [11:0] out_pc;
  logic        out_ready;
  logic        redir_valid, redir_j, redir_jal, redir_jr, redir_bne, redir_blt, redir_bex;
  logic        cond_ne, cond_lt, cond_rstatus_nz;
  logic [11:0] redir_pc;
  logic [16:0] redir_imm;
  logic [26:0] redir_target;
  logic [31:0] redir_rd_val;
  logic        redir_taken;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  fetch_pc_unit dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_insn(out_insn), .out_pc(out_pc), .out_ready(out_ready),
    .redir_valid(redir_valid), .redir_j(redir_j), .redir_jal(redir_jal), .redir_jr(redir_jr),
    .redir_bne(redir_bne), .redir_blt(redir_blt), .redir_bex(redir_bex),
    .cond_ne(cond_ne), .cond_lt(cond_lt), .cond_rstatus_nz(cond_rstatus_nz),
    .redir_pc(redir_pc), .redir_imm(redir_imm), .redir_target(redir_target),
    .redir_rd_val(redir_rd_val), .redir_taken(redir_taken), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_redir();
    redir_valid = 1'b0; redir_j = 1'b0; redir_jal = 1'b0; redir_jr = 1'b0;
    redir_bne = 1'b0; redir_blt = 1'b0; redir_bex = 1'b0;
    cond_ne = 1'b0; cond_lt = 1'b0; cond_rstatus_nz = 1'b0;
    redir_pc = 12'h000; redir_imm = 17'h00000; redir_target = 27'h0; redir_rd_val = 32'h0;
  endtask

  // From FETCH: one wait cycle, then a one-cycle ack carrying rdata.
  task automatic fetch_one(input logic [31:0] rdata);
    step();
    imem_ack = 1'b1; imem_rdata = rdata;
    step();
    imem_ack = 1'b0; imem_rdata = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; out_ready = 1'b0;
    clr_redir();

    // Reset and first fetch.
    step(); step();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", fetch_count, 16'd0);
    chk("rst_addr", imem_addr, 12'h000);
    reset = 1'b1;
    step();
    chk("f0_req", imem_req, 1'b1);
    chk("f0_addr", imem_addr, 12'h000);
    fetch_one(32'h28000005);
    chk("f0_valid", out_valid, 1'b1);
    chk("f0_insn", out_insn, 32'h28000005);
    chk("f0_pc", out_pc, 12'h000);
    chk("f0_req_hold", imem_req, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("f1_addr", imem_addr, 12'h001);
    chk("f1_count", fetch_count, 16'd1);
    chk("f1_valid", out_valid, 1'b0);

    // Taken blt in HOLD squashes without counting; target 10+1-4 = 7.
    fetch_one(32'h11111111);
    chk("blt_hold_pc", out_pc, 12'h001);
    redir_valid = 1'b1; redir_blt = 1'b1; cond_lt = 1'b1;
    redir_pc = 12'd10; redir_imm = 17'h1FFFC;
    out_ready = 1'b1;
    #1;
    chk("blt_taken", redir_taken, 1'b1);
    step();
    clr_redir(); out_ready = 1'b0;
    chk("blt_valid", out_valid, 1'b0);
    chk("blt_count", fetch_count, 16'd1);
    chk("blt_addr", imem_addr, 12'h007);

    // Non-taken and invalid redirects are inert.
    redir_valid = 1'b1; redir_bne = 1'b1; cond_ne = 1'b0; redir_imm = 17'h00010;
    #1;
    chk("bne_nt", redir_taken, 1'b0);
    redir_valid = 1'b0; redir_jr = 1'b1;
    #1;
    chk("inval_jr", redir_taken, 1'b0);
    step();
    clr_redir();
    chk("nt_addr", imem_addr, 12'h007);

    // j in HOLD lands FETCH on address 3.
    fetch_one(32'h22222222);
    chk("j_hold_pc", out_pc, 12'h007);
    redir_valid = 1'b1; redir_j = 1'b1; redir_target = 27'h0000003;
    step();
    clr_redir();
    chk("j_addr", imem_addr, 12'h003);

    // jr in FETCH with no ack -> DROP, old address held until ack.
    redir_valid = 1'b1; redir_jr = 1'b1; redir_rd_val = 32'h00000040;
    step();
    clr_redir();
    for (int i = 0; i < 2; i++) begin
      chk("drop_addr", imem_addr, 12'h003);
      chk("drop_req", imem_req, 1'b1);
      step();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    step();
    imem_ack = 1'b0;
    chk("drop_valid", out_valid, 1'b0);
    chk("drop_new_addr", imem_addr, 12'h040);

    // Decode stalls for 5 cycles in HOLD.
    fetch_one(32'hAABBCCDD);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_insn", out_insn, 32'hAABBCCDD);
      chk("stall_pc", out_pc, 12'h040);
      chk("stall_req", imem_req, 1'b0);
      chk("stall_count", fetch_count, 16'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("stall_count2", fetch_count, 16'd2);
    chk("stall_next", imem_addr, 12'h041);

    // jal coinciding with ack discards data and refetches at 0xFFF.
    imem_ack = 1'b1; imem_rdata = 32'h33333333;
    redir_valid = 1'b1; redir_jal = 1'b1; redir_target = 27'h0000FFF;
    step();
    imem_ack = 1'b0; clr_redir();
    chk("jal_valid", out_valid, 1'b0);
    chk("jal_addr", imem_addr, 12'hFFF);
    fetch_one(32'h08000002);
    chk("wrap_pc", out_pc, 12'hFFF);
    chk("wrap_insn", out_insn, 32'h08000002);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("wrap_addr", imem_addr, 12'h000);
    chk("wrap_count", fetch_count, 16'd3);

    // Reset while awaiting ack; ack during reset is ignored.
    step();
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h44444444;
    step();
    imem_ack = 1'b0;
    chk("mrst_req", imem_req, 1'b0);
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_insn", out_insn, 32'h0);
    chk("mrst_pc", out_pc, 12'h000);
    chk("mrst_count", fetch_count, 16'd0);
    reset = 1'b1;
    step();
    chk("mrst_addr", imem_addr, 12'h000);
    chk("mrst_req2", imem_req, 1'b1);
    chk("mrst_valid2", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
